// File: rtl/video_source_mux.sv
// video_source_mux
//   Frame-synchronous selector for NUM_SOURCES RGB pixel streams that share
//   one timing generator. The requested source (sel, from switches) is
//   synchronised and only taken over at a frame start, so a picture never
//   tears. Pixel data and sync signals leave through a PIPE_STAGES-deep,
//   mutually aligned register pipeline.
//
//   Optional feature macro: VIDEO_SOURCE_MUX_BLANK_FRAME_EN
//     When defined, every source change is followed by one all-black frame.
//     If the request changes again during that frame, there is another
//     black frame.
//
// Ports
//   clk_rgb       pixel clock (only clock)
//   rst_n         asynchronous active-low reset, released synchronously
//   sel           requested source index (asynchronous to clk_rgb)
//   src_r/g/b     packed colours, source i at [i*COLOR_WIDTH +: COLOR_WIDTH]
//   in_hs/vs/de   timing from pixel_iterator (vs active-high)
//   r, g, b       selected colour, PIPE_STAGES cycles after the input
//   hs, vs, de    in_hs/in_vs/in_de delayed by PIPE_STAGES
//   active_sel    raw index of the source currently shown
//   switch_pulse  one-cycle pulse after the frame start that changed active_sel
module video_source_mux #(
  parameter int NUM_SOURCES = 4,
  parameter int COLOR_WIDTH = 8,
  parameter int PIPE_STAGES = 2,
  parameter int SEL_WIDTH   = 4,
  parameter int DEFAULT_SEL = 0
) (
  input  logic                               clk_rgb,
  input  logic                               rst_n,
  input  logic [SEL_WIDTH-1:0]               sel,
  input  logic [NUM_SOURCES*COLOR_WIDTH-1:0] src_r,
  input  logic [NUM_SOURCES*COLOR_WIDTH-1:0] src_g,
  input  logic [NUM_SOURCES*COLOR_WIDTH-1:0] src_b,
  input  logic                               in_hs,
  input  logic                               in_vs,
  input  logic                               in_de,
  output logic [COLOR_WIDTH-1:0]             r,
  output logic [COLOR_WIDTH-1:0]             g,
  output logic [COLOR_WIDTH-1:0]             b,
  output logic                               hs,
  output logic                               vs,
  output logic                               de,
  output logic [SEL_WIDTH-1:0]               active_sel,
  output logic                               switch_pulse
);

  localparam logic [SEL_WIDTH-1:0] DEF_SEL = SEL_WIDTH'(DEFAULT_SEL);

`ifdef VIDEO_SOURCE_MUX_BLANK_FRAME_EN
  typedef enum logic [0:0] {RUN = 1'b0, BLANK = 1'b1} state_t;
`else
  typedef enum logic [0:0] {RUN = 1'b0} state_t;
`endif

  // Reset synchroniser: assertion is immediate, release waits two edges.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk_rgb or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  state_t                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
  logic [SEL_WIDTH-1:0]   active_sel_q, active_sel_d;
  logic                   switch_pulse_q, switch_pulse_d;
  logic                   vs_prev_q, vs_prev_d;
  logic [COLOR_WIDTH-1:0] r_q [PIPE_STAGES];
  logic [COLOR_WIDTH-1:0] g_q [PIPE_STAGES];
  logic [COLOR_WIDTH-1:0] b_q [PIPE_STAGES];
  logic [COLOR_WIDTH-1:0] r_d [PIPE_STAGES];
  logic [COLOR_WIDTH-1:0] g_d [PIPE_STAGES];
  logic [COLOR_WIDTH-1:0] b_d [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] hs_q, hs_d, vs_q, vs_d, de_q, de_d;

  logic                   frame_start;
  logic                   sel_change;
  logic                   blank;
  logic [COLOR_WIDTH-1:0] mux_r, mux_g, mux_b;

  always_comb begin
    sel_s1_d    = sel;
    sel_s2_d    = sel_s1_q;
    vs_prev_d   = in_vs;
    frame_start = in_vs & ~vs_prev_q;
    sel_change  = frame_start && (sel_s2_q != active_sel_q);

    active_sel_d   = sel_change ? sel_s2_q : active_sel_q;
    switch_pulse_d = sel_change;

    state_d = state_q;
`ifdef VIDEO_SOURCE_MUX_BLANK_FRAME_EN
    // Any frame start re-decides: a change (from RUN or BLANK) blanks the
    // coming frame, an unchanged request returns to RUN.
    if (frame_start) state_d = sel_change ? BLANK : RUN;
    blank = (state_q == BLANK);
`else
    blank = 1'b0;
`endif

    // An index with no matching source leaves the mux at black.
    mux_r = '0;
    mux_g = '0;
    mux_b = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (active_sel_q == SEL_WIDTH'(i)) begin
        mux_r = src_r[i*COLOR_WIDTH +: COLOR_WIDTH];
        mux_g = src_g[i*COLOR_WIDTH +: COLOR_WIDTH];
        mux_b = src_b[i*COLOR_WIDTH +: COLOR_WIDTH];
      end
    end
    if (!in_de || blank) begin
      mux_r = '0;
      mux_g = '0;
      mux_b = '0;
    end

    r_d[0]  = mux_r;
    g_d[0]  = mux_g;
    b_d[0]  = mux_b;
    hs_d[0] = in_hs;
    vs_d[0] = in_vs;
    de_d[0] = in_de;
    for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
      r_d[k]  = r_q[k-1];
      g_d[k]  = g_q[k-1];
      b_d[k]  = b_q[k-1];
      hs_d[k] = hs_q[k-1];
      vs_d[k] = vs_q[k-1];
      de_d[k] = de_q[k-1];
    end
  end

  always_ff @(posedge clk_rgb or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q        <= RUN;
      sel_s1_q       <= '0;
      sel_s2_q       <= '0;
      active_sel_q   <= DEF_SEL;
      switch_pulse_q <= 1'b0;
      vs_prev_q      <= 1'b0;
      hs_q           <= '0;
      vs_q           <= '0;
      de_q           <= '0;
      for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
        r_q[k] <= '0;
        g_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      state_q        <= state_d;
      sel_s1_q       <= sel_s1_d;
      sel_s2_q       <= sel_s2_d;
      active_sel_q   <= active_sel_d;
      switch_pulse_q <= switch_pulse_d;
      vs_prev_q      <= vs_prev_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      de_q           <= de_d;
      for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
        r_q[k] <= r_d[k];
        g_q[k] <= g_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  assign r            = r_q[PIPE_STAGES-1];
  assign g            = g_q[PIPE_STAGES-1];
  assign b            = b_q[PIPE_STAGES-1];
  assign hs           = hs_q[PIPE_STAGES-1];
  assign vs           = vs_q[PIPE_STAGES-1];
  assign de           = de_q[PIPE_STAGES-1];
  assign active_sel   = active_sel_q;
  assign switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_video_source_mux.sv
// Directed testbench for video_source_mux (NUM_SOURCES=4, COLOR_WIDTH=8,
// PIPE_STAGES=2, SEL_WIDTH=4). Source k shows the constant colour
// {0x10+k, 0x20+k, 0x30+k}. Each frame: 2 vsync cycles, 4 back porch,
// 8 active pixels, 4 trailing blank cycles.
module tb_video_source_mux;

`ifdef VIDEO_SOURCE_MUX_BLANK_FRAME_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk_rgb = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] src_r = {8'h13, 8'h12, 8'h11, 8'h10};
  logic [31:0] src_g = {8'h23, 8'h22, 8'h21, 8'h20};
  logic [31:0] src_b = {8'h33, 8'h32, 8'h31, 8'h30};
  logic        in_hs = 1'b0, in_vs = 1'b0, in_de = 1'b0;
  logic [7:0]  r, g, b;
  logic        hs, vs, de;
  logic [3:0]  active_sel;
  logic        switch_pulse;

  int errors = 0;
  int checks = 0;

  int pix_cnt = 0, pix_bad = 0, blank_viol = 0, pulse_cnt = 0;
  logic [23:0] exp_rgb = 24'h0;

  typedef struct {
    int         c1_at;
    logic [3:0] c1_sel;
    int         c2_at;
    logic [3:0] c2_sel;
    logic [23:0] rgb;
    logic [3:0] act;
    int         pulses;
  } fr_t;

  video_source_mux #(
    .NUM_SOURCES(4), .COLOR_WIDTH(8), .PIPE_STAGES(2), .SEL_WIDTH(4), .DEFAULT_SEL(0)
  ) dut (
    .clk_rgb(clk_rgb), .rst_n(rst_n), .sel(sel),
    .src_r(src_r), .src_g(src_g), .src_b(src_b),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de),
    .active_sel(active_sel), .switch_pulse(switch_pulse)
  );

  always #5 clk_rgb = ~clk_rgb;

  // Output monitor: accumulates pixel statistics that the tests difference.
  always @(negedge clk_rgb) begin
    if (de) begin
      pix_cnt <= pix_cnt + 1;
      if ({r, g, b} !== exp_rgb) pix_bad <= pix_bad + 1;
    end else if ({r, g, b} !== 24'h0) begin
      blank_viol <= blank_viol + 1;
    end
    if (switch_pulse) pulse_cnt <= pulse_cnt + 1;
  end

  function automatic logic [23:0] src_rgb(input int k);
    src_rgb = {8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30 + 8'(k)};
  endfunction

  task automatic drv(input logic h, input logic v, input logic d);
    @(posedge clk_rgb);
    #1;
    in_hs = h;
    in_vs = v;
    in_de = d;
  endtask

  task automatic frame(input int c1_at, input logic [3:0] c1_sel,
                       input int c2_at, input logic [3:0] c2_sel);
    repeat (2) drv(1'b0, 1'b1, 1'b0);
    repeat (4) drv(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == c1_at) sel = c1_sel;
      if (i == c2_at) sel = c2_sel;
      drv(1'b0, 1'b0, 1'b1);
    end
    drv(1'b1, 1'b0, 1'b0);
    repeat (3) drv(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel   = 4'd0;
    #12;
    checks++;
    if ({r, g, b} !== 24'h0) begin
      errors++; $display("FAIL reset_rgb: got %h expected 000000", {r, g, b});
    end
    checks++;
    if ({hs, vs, de} !== 3'b000) begin
      errors++; $display("FAIL reset_sync: got %b expected 000", {hs, vs, de});
    end
    checks++;
    if (active_sel !== 4'd0 || switch_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_sel: got sel=%0d pulse=%b expected sel=0 pulse=0",
                         active_sel, switch_pulse);
    end
    @(posedge clk_rgb);
    #1 rst_n = 1'b1;
    repeat (5) drv(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_latency();
    exp_rgb = src_rgb(0);
    drv(1'b0, 1'b0, 1'b1);
    @(negedge clk_rgb);
    checks++;
    if (de !== 1'b0) begin errors++; $display("FAIL lat_early0: got de=%b expected 0", de); end
    drv(1'b1, 1'b0, 1'b0);
    @(negedge clk_rgb);
    checks++;
    if (de !== 1'b0) begin errors++; $display("FAIL lat_early1: got de=%b expected 0", de); end
    drv(1'b0, 1'b0, 1'b0);
    @(negedge clk_rgb);
    checks++;
    if ({r, g, b} !== 24'h102030) begin
      errors++; $display("FAIL lat_rgb: got %h expected 102030", {r, g, b});
    end
    checks++;
    if ({hs, vs, de} !== 3'b001) begin
      errors++; $display("FAIL lat_sync_a: got %b expected 001", {hs, vs, de});
    end
    drv(1'b0, 1'b0, 1'b0);
    @(negedge clk_rgb);
    checks++;
    if ({hs, vs, de} !== 3'b100) begin
      errors++; $display("FAIL lat_sync_b: got %b expected 100", {hs, vs, de});
    end
    checks++;
    if ({r, g, b} !== 24'h0) begin
      errors++; $display("FAIL lat_rgb_b: got %h expected 000000", {r, g, b});
    end
    repeat (3) drv(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    fr_t t[2];
    int p0, b0, v0, u0;
    t[0] = '{1, 4'd3, 5, 4'd0, src_rgb(0), 4'd0, 0};
    t[1] = '{-1, 4'd0, -1, 4'd0, src_rgb(0), 4'd0, 0};
    for (int i = 0; i < 2; i++) begin
      p0 = pix_cnt; b0 = pix_bad; v0 = blank_viol; u0 = pulse_cnt; exp_rgb = t[i].rgb;
      frame(t[i].c1_at, t[i].c1_sel, t[i].c2_at, t[i].c2_sel);
      checks++;
      if (pix_cnt - p0 !== 8) begin errors++; $display("FAIL glitch_pix[%0d]: got %0d expected 8", i, pix_cnt - p0); end
      checks++;
      if (pix_bad - b0 !== 0) begin errors++; $display("FAIL glitch_rgb[%0d]: got %0d wrong pixels expected 0 (want %h)", i, pix_bad - b0, t[i].rgb); end
      checks++;
      if (blank_viol - v0 !== 0) begin errors++; $display("FAIL glitch_blank[%0d]: got %0d expected 0", i, blank_viol - v0); end
      checks++;
      if (pulse_cnt - u0 !== t[i].pulses) begin errors++; $display("FAIL glitch_pulse[%0d]: got %0d expected %0d", i, pulse_cnt - u0, t[i].pulses); end
      checks++;
      if (active_sel !== t[i].act) begin errors++; $display("FAIL glitch_act[%0d]: got %0d expected %0d", i, active_sel, t[i].act); end
    end
  endtask

  task automatic test_switch();
    fr_t t[3];
    int p0, b0, v0, u0;
    t[0] = '{3, 4'd2, -1, 4'd0, src_rgb(0), 4'd0, 0};
    t[1] = '{-1, 4'd0, -1, 4'd0, BLANK_EN ? 24'h0 : src_rgb(2), 4'd2, 1};
    t[2] = '{-1, 4'd0, -1, 4'd0, src_rgb(2), 4'd2, 0};
    for (int i = 0; i < 3; i++) begin
      p0 = pix_cnt; b0 = pix_bad; v0 = blank_viol; u0 = pulse_cnt; exp_rgb = t[i].rgb;
      frame(t[i].c1_at, t[i].c1_sel, t[i].c2_at, t[i].c2_sel);
      checks++;
      if (pix_cnt - p0 !== 8) begin errors++; $display("FAIL switch_pix[%0d]: got %0d expected 8", i, pix_cnt - p0); end
      checks++;
      if (pix_bad - b0 !== 0) begin errors++; $display("FAIL switch_rgb[%0d]: got %0d wrong pixels expected 0 (want %h)", i, pix_bad - b0, t[i].rgb); end
      checks++;
      if (blank_viol - v0 !== 0) begin errors++; $display("FAIL switch_blank[%0d]: got %0d expected 0", i, blank_viol - v0); end
      checks++;
      if (pulse_cnt - u0 !== t[i].pulses) begin errors++; $display("FAIL switch_pulse[%0d]: got %0d expected %0d", i, pulse_cnt - u0, t[i].pulses); end
      checks++;
      if (active_sel !== t[i].act) begin errors++; $display("FAIL switch_act[%0d]: got %0d expected %0d", i, active_sel, t[i].act); end
    end
  endtask

  task automatic test_invalid();
    fr_t t[5];
    int p0, b0, v0, u0;
    t[0] = '{2, 4'd5, -1, 4'd0, src_rgb(2), 4'd2, 0};
    t[1] = '{-1, 4'd0, -1, 4'd0, 24'h0, 4'd5, 1};
    t[2] = '{2, 4'd1, -1, 4'd0, 24'h0, 4'd5, 0};
    t[3] = '{-1, 4'd0, -1, 4'd0, BLANK_EN ? 24'h0 : src_rgb(1), 4'd1, 1};
    t[4] = '{-1, 4'd0, -1, 4'd0, src_rgb(1), 4'd1, 0};
    for (int i = 0; i < 5; i++) begin
      p0 = pix_cnt; b0 = pix_bad; v0 = blank_viol; u0 = pulse_cnt; exp_rgb = t[i].rgb;
      frame(t[i].c1_at, t[i].c1_sel, t[i].c2_at, t[i].c2_sel);
      checks++;
      if (pix_cnt - p0 !== 8) begin errors++; $display("FAIL invalid_pix[%0d]: got %0d expected 8", i, pix_cnt - p0); end
      checks++;
      if (pix_bad - b0 !== 0) begin errors++; $display("FAIL invalid_rgb[%0d]: got %0d wrong pixels expected 0 (want %h)", i, pix_bad - b0, t[i].rgb); end
      checks++;
      if (blank_viol - v0 !== 0) begin errors++; $display("FAIL invalid_blank[%0d]: got %0d expected 0", i, blank_viol - v0); end
      checks++;
      if (pulse_cnt - u0 !== t[i].pulses) begin errors++; $display("FAIL invalid_pulse[%0d]: got %0d expected %0d", i, pulse_cnt - u0, t[i].pulses); end
      checks++;
      if (active_sel !== t[i].act) begin errors++; $display("FAIL invalid_act[%0d]: got %0d expected %0d", i, active_sel, t[i].act); end
    end
  endtask

  // Source change, then a second change while the first switch frame runs.
  task automatic test_blank_frame();
    fr_t t[4];
    int p0, b0, v0, u0;
    t[0] = '{2, 4'd2, -1, 4'd0, src_rgb(1), 4'd1, 0};
    t[1] = '{3, 4'd3, -1, 4'd0, BLANK_EN ? 24'h0 : src_rgb(2), 4'd2, 1};
    t[2] = '{-1, 4'd0, -1, 4'd0, BLANK_EN ? 24'h0 : src_rgb(3), 4'd3, 1};
    t[3] = '{-1, 4'd0, -1, 4'd0, src_rgb(3), 4'd3, 0};
    for (int i = 0; i < 4; i++) begin
      p0 = pix_cnt; b0 = pix_bad; v0 = blank_viol; u0 = pulse_cnt; exp_rgb = t[i].rgb;
      frame(t[i].c1_at, t[i].c1_sel, t[i].c2_at, t[i].c2_sel);
      checks++;
      if (pix_cnt - p0 !== 8) begin errors++; $display("FAIL blankfr_pix[%0d]: got %0d expected 8", i, pix_cnt - p0); end
      checks++;
      if (pix_bad - b0 !== 0) begin errors++; $display("FAIL blankfr_rgb[%0d]: got %0d wrong pixels expected 0 (want %h)", i, pix_bad - b0, t[i].rgb); end
      checks++;
      if (blank_viol - v0 !== 0) begin errors++; $display("FAIL blankfr_blank[%0d]: got %0d expected 0", i, blank_viol - v0); end
      checks++;
      if (pulse_cnt - u0 !== t[i].pulses) begin errors++; $display("FAIL blankfr_pulse[%0d]: got %0d expected %0d", i, pulse_cnt - u0, t[i].pulses); end
      checks++;
      if (active_sel !== t[i].act) begin errors++; $display("FAIL blankfr_act[%0d]: got %0d expected %0d", i, active_sel, t[i].act); end
    end
  endtask

  task automatic test_reset_mid_line();
    int p0, b0, u0;
    exp_rgb = src_rgb(3);
    repeat (2) drv(1'b0, 1'b1, 1'b0);
    repeat (4) drv(1'b0, 1'b0, 1'b0);
    repeat (4) drv(1'b1, 1'b0, 1'b1);
    @(negedge clk_rgb);
    checks++;
    if ({hs, de, r, g, b} !== {2'b11, src_rgb(3)}) begin
      errors++; $display("FAIL midrst_pre: got hs=%b de=%b rgb=%h expected hs=1 de=1 rgb=%h",
                         hs, de, {r, g, b}, src_rgb(3));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({r, g, b, hs, vs, de} !== 27'h0) begin
      errors++; $display("FAIL midrst_out: got rgb=%h hs/vs/de=%b expected all 0",
                         {r, g, b}, {hs, vs, de});
    end
    checks++;
    if (active_sel !== 4'd0 || switch_pulse !== 1'b0) begin
      errors++; $display("FAIL midrst_sel: got sel=%0d pulse=%b expected 0/0", active_sel, switch_pulse);
    end
    in_de = 1'b0;
    in_hs = 1'b0;
    sel   = 4'd0;
    #3 rst_n = 1'b1;
    repeat (5) drv(1'b0, 1'b0, 1'b0);
    p0 = pix_cnt; b0 = pix_bad; u0 = pulse_cnt; exp_rgb = src_rgb(0);
    frame(-1, 4'd0, -1, 4'd0);
    checks++;
    if (pix_cnt - p0 !== 8 || pix_bad - b0 !== 0) begin
      errors++; $display("FAIL midrst_frame: got %0d pixels %0d wrong expected 8 pixels 0 wrong",
                         pix_cnt - p0, pix_bad - b0);
    end
    checks++;
    if (pulse_cnt - u0 !== 0 || active_sel !== 4'd0) begin
      errors++; $display("FAIL midrst_after: got pulses=%0d sel=%0d expected 0/0", pulse_cnt - u0, active_sel);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_switch();
    test_invalid();
    test_blank_frame();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_source_mux.md
Name: video_source_mux

Overview:
- Parametrised successor to the top-level switch-selected RGB mux. Selects one of NUM_SOURCES pixel streams that share one timing generator.
- Output is registered and pipelined, with the sync signals delayed to match the pixel data.
- The source selection is synchronised and only changes at a frame boundary, so a frame never tears mid-picture.
- Sits between the source generators (pixel_iterator-driven test and game renderers) and dvi_tx, in the clk_rgb domain.

Parameters:
- NUM_SOURCES, 4, number of input RGB sources; must be >= 2.
- COLOR_WIDTH, 8, bits per colour channel.
- PIPE_STAGES, 2, clk_rgb cycles from input to output; must be >= 1.
- SEL_WIDTH, 4, width of the raw select input (driven from switches).
- DEFAULT_SEL, 0, active source after reset.

Ports:
- clk_rgb  input  1  pixel clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  SEL_WIDTH  requested source index; asynchronous to clk_rgb (switches).
- src_r  input  NUM_SOURCES*COLOR_WIDTH  red for each source, packed; source i occupies [i*COLOR_WIDTH +: COLOR_WIDTH].
- src_g  input  NUM_SOURCES*COLOR_WIDTH  green for each source, packed the same way.
- src_b  input  NUM_SOURCES*COLOR_WIDTH  blue for each source, packed the same way.
- in_hs  input  1  horizontal sync from pixel_iterator.
- in_vs  input  1  vertical sync from pixel_iterator; active-high.
- in_de  input  1  data enable from pixel_iterator.
- r, g, b  output  COLOR_WIDTH each  selected pixel colour.
- hs, vs, de  output  1 each  in_hs/in_vs/in_de delayed by PIPE_STAGES.
- active_sel  output  SEL_WIDTH  source currently shown; SEL_WIDTH-wide so a held invalid index is visible.
- switch_pulse  output  1  one-cycle pulse at the frame start where active_sel changes.

Behaviour:
- Reset (async assert, sync release to clk_rgb):
  - r, g, b, hs, vs, de = 0.
  - active_sel = DEFAULT_SEL; switch_pulse = 0.
  - All pipeline and synchroniser flops = 0.
  - FSM = RUN.
- sel passes through a 2-flop synchroniser to give sel_sync. sel_sync lags sel by 2 cycles.
- frame_start: one-cycle strobe when in_vs is 1 and its previous-cycle registered value is 0.
- Only frame_start updates active_sel. On a frame_start cycle:
  - if sel_sync != active_sel: active_sel <= sel_sync and switch_pulse = 1 on the following cycle;
  - otherwise nothing changes.
- sel changes that happen and revert between two frame_starts are ignored.
- Invalid index (active_sel >= NUM_SOURCES): output black for the whole frame. active_sel still reports the raw index.
- Datapath:
  - Stage 1 registers the mux output: the colour of source active_sel, or 0 when in_de = 0 or the index is invalid. Stage 1 also registers hs/vs/de.
  - Stages 2..PIPE_STAGES are plain delay registers.
  - Total latency for r/g/b/hs/vs/de is exactly PIPE_STAGES cycles, and all six stay aligned.
- The select that a pixel uses is the active_sel value in the cycle that pixel enters stage 1. On a frame_start cycle the old select applies; the new one applies from the next cycle. The pixel iterator's vertical back porch guarantees this happens before any de.
- Outputs r/g/b are 0 on every cycle where de is 0.
- FSM without the optional feature: a single RUN state.

Optional Feature:
- Macro: VIDEO_SOURCE_MUX_BLANK_FRAME_EN.
- Defined: adds a BLANK state to the FSM.
  - RUN -> BLANK on a frame_start that changes active_sel.
  - In BLANK, r/g/b are forced to 0 for the whole frame; hs/vs/de are unaffected.
  - BLANK -> RUN on the next frame_start if sel_sync == active_sel.
  - Otherwise BLANK -> BLANK: active_sel is updated again, switch_pulse fires, and one more black frame follows.
  - Reset while in BLANK returns the FSM to RUN.
- Not defined: a change of source takes effect immediately at the frame boundary, with no black frame.

Test Plan:
- Reset with NUM_SOURCES=4, PIPE_STAGES=2, src0 = constant 0x102030 -> after release, r/g/b = 0x10/0x20/0x30 exactly 2 cycles after the first in_de=1; hs/vs/de equal the inputs delayed by 2 cycles.
- sel changes 0 -> 2 mid-frame (line 100) -> output stays source 0 until the next in_vs rising edge; then active_sel = 2, switch_pulse is high for 1 cycle, and the first active pixel of the new frame is source 2.
- sel pulses 0 -> 3 -> 0 between two frame_starts -> active_sel stays 0 and switch_pulse never fires.
- sel = 5 -> from the next frame r/g/b = 0 on all pixels and active_sel = 5; sel = 1 -> source 1 is shown from the following frame.
- rst_n asserted mid-line with de high -> all outputs are 0 the same cycle (asynchronous), and active_sel = DEFAULT_SEL.
- With VIDEO_SOURCE_MUX_BLANK_FRAME_EN, sel 0 -> 1 -> exactly one all-black frame, then source 1; a second change of sel during the black frame -> one more black frame, then the newest source.
